cq_viola_nios2_dct_reader: RTL and testbench
============================================

// Module: cq_viola_nios2_dct_reader
// PURPOSE
//  Receive-side drain for Nios II OCI data-capture-trace (DCT) frames. Each frame is a
//  30-bit dct_buffer plus a 4-bit dct_count, delivered with a 1-cycle strobe.
//  Accepted frames are queued in a FIFO. Host software reads them through an Avalon-MM
//  slave, along with status and a drop counter. Sits beside the OCI on the debug fabric.
// PARAMETERS
//  FIFO_AW       4  FIFO address width; depth = 2**FIFO_AW entries of 34 bits
//  ENABLE_RESET  1  value loaded into the capture-enable bit at reset
// PORTS
//  clk            in   1   single clock; all logic on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  dct_buffer     in   30  captured frame payload
//  dct_count      in   4   number of valid 3-bit fields in dct_buffer (legal 1..10)
//  dct_valid      in   1   1-cycle strobe: dct_buffer/dct_count hold a complete frame
//  test_ending    in   1   level; while high, capture is inhibited
//  test_has_ended in   1   level; latched into sticky 'ended' status bit
//  address        in   2   Avalon word address
//  read           in   1   Avalon read request
//  write          in   1   Avalon write request
//  writedata      in   32  Avalon write data
//  readdata       out  32  Avalon read data, registered
// BEHAVIOUR
//  Reset: readdata=0, FIFO empty, level=0, overflow=0, ended=0, drop_cnt=0, enable=ENABLE_RESET.
//  Register map:
//   0 STATUS (RO): [0]empty [1]full [2]overflow [3]enable [4]ended
//                  [FIFO_AW+8:8]level [23:16]drop_cnt; all other bits 0
//   1 DATA_LO (RO, no side effect): {2'b0, head.buffer}; returns 0 when empty
//   2 DATA_HI (RO, pops): {28'b0, head.count}; pops head if not empty; returns 0 when empty
//   3 CTRL (WO): [0]enable  [1]=1 clears overflow and drop_cnt
//                [2]=1 flushes FIFO (level->0)
//  Read latency: fixed 1 cycle; readdata is updated on the cycle after read=1 and holds
//   until the next read. No waitrequest. Reads of address 3 return 0.
//  Push: dct_valid & enable & ~test_ending & (dct_count!=0).
//   count 0 -> frame silently discarded, no overflow.
//   count >10 -> stored as-is, no clamping.
//  Full: push attempted when full and no pop in the same cycle -> frame dropped,
//   overflow<=1 (sticky), drop_cnt+1 (saturates at 255).
//  Simultaneous push+pop: when full, both take effect and level is unchanged; when empty,
//   the pop is a no-op and the push is accepted (level 0->1). DATA_HI then reads 0.
//  Pointers wrap modulo 2**FIFO_AW. level is FIFO_AW+1 bits and reaches 2**FIFO_AW when full.
//  CTRL write concurrent with events:
//   flush has priority over push and pop in the same cycle; level becomes 0 and the frame
//   pushed in that cycle is lost without being counted.
//   Clear has priority over overflow set and drop increment in the same cycle.
//  ended: set on any cycle with test_has_ended=1; cleared only by reset.
//  Reset asserted mid-operation: all state returns to reset values immediately;
//   an in-flight read returns nothing.
// TESTING
//  1 Reset, then 3 strobes (buf 0x1234567/cnt 5, 0x3FFFFFFF/10, 0x1/1).
//    -> STATUS level=3; DATA_LO/DATA_HI pairs return the frames in order; then empty=1.
//  2 With FIFO_AW=4, push 18 frames with no reads -> full=1, overflow=1, drop_cnt=2,
//    level=16; first 16 frames read back intact.
//  3 Hold FIFO full, then pulse dct_valid in the same cycle as a DATA_HI read
//    -> level stays 16; new frame appears last; drop_cnt unchanged.
//  4 Strobe with dct_count=0; strobe while test_ending=1; strobe with enable cleared via CTRL
//    -> level stays 0 and drop_cnt stays 0.
//  5 Write CTRL=0x7 with level=5 and overflow=1 -> level=0, overflow=0, drop_cnt=0, enable=1.
//  6 Pulse test_has_ended -> ended=1 persists; pulse reset_n low mid-burst -> STATUS reads
//    0x00000009 (ENABLE_RESET=1, empty).

Source files
------------

// File: rtl/cq_viola_nios2_dct_reader.sv
// Queues Nios II OCI data-capture-trace frames and serves them to host software over Avalon-MM.
// Readdata is registered with 1-cycle read latency; a full FIFO drops frames and counts them.
module cq_viola_nios2_dct_reader #(
   parameter int FIFO_AW      = 4,
   parameter bit ENABLE_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [29:0] dct_buffer,
   input  logic [3:0]  dct_count,
   input  logic        dct_valid,
   input  logic        test_ending,
   input  logic        test_has_ended,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

   logic [33:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   level;
   logic               overflow, enable, ended;
   logic [7:0]         drop_cnt;

   logic        empty, full, push_req, pop_ok, push_ok, drop, ctrl_wr, flush, clear;
   logic [33:0] head;
   logic [31:0] status;
   logic        unused_wdata;

   assign unused_wdata = ^writedata[31:3];

   assign empty    = (level == '0);
   assign full     = (level == LEVEL_FULL);
   assign head     = mem[rd_ptr];
   assign push_req = dct_valid & enable & ~test_ending & (dct_count != 4'd0);
   assign pop_ok   = read & (address == 2'd2) & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req & (~full | pop_ok);
   assign ctrl_wr  = write & (address == 2'd3);
   assign flush    = ctrl_wr & writedata[2];
   assign clear    = ctrl_wr & writedata[1];
   assign drop     = push_req & full & ~pop_ok & ~flush;

   always_comb begin
      status                = '0;
      status[0]             = empty;
      status[1]             = full;
      status[2]             = overflow;
      status[3]             = enable;
      status[4]             = ended;
      status[FIFO_AW+8:8]   = level;
      status[23:16]         = drop_cnt;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {dct_count, dct_buffer};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
         enable   <= ENABLE_RESET;
         ended    <= 1'b0;
      end else begin
         if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end
         if (ctrl_wr)        enable <= writedata[0];
         if (test_has_ended) ended  <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (read) begin
         case (address)
            2'd0:    readdata <= status;
            2'd1:    readdata <= empty ? 32'd0 : {2'b00, head[29:0]};
            2'd2:    readdata <= empty ? 32'd0 : {28'd0, head[33:30]};
            default: readdata <= 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_cq_viola_nios2_dct_reader.sv
// Directed scenarios plus a randomized run, all checked against a queue-based model of the drain.
module tb_cq_viola_nios2_dct_reader;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        dct_valid, test_ending, test_has_ended;
   logic [1:0]  address;
   logic        read, write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   int tests = 0;
   int fails = 0;

   logic [33:0] q[$];
   logic        m_ovf, m_en, m_ended;
   int          m_drop;
   logic [31:0] exp_rd;

   cq_viola_nios2_dct_reader #(.FIFO_AW(4), .ENABLE_RESET(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
      .test_ending(test_ending), .test_has_ended(test_has_ended),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .readdata(readdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = (q.size() == 0);
      s[1]     = (q.size() == DEPTH);
      s[2]     = m_ovf;
      s[3]     = m_en;
      s[4]     = m_ended;
      s[12:8]  = 5'(q.size());
      s[23:16] = 8'(m_drop);
      return s;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf = 0; m_en = 1; m_ended = 0; m_drop = 0; exp_rd = '0;
   endtask

   // One clock: predict from the inputs currently driven, advance, compare readdata.
   task automatic tick();
      logic [31:0] nrd;
      bit pushreq, pop, flush, clr, dropped;
      nrd = exp_rd;
      if (read) begin
         case (address)
            2'd0: nrd = model_status();
            2'd1: nrd = (q.size() > 0) ? {2'b00, q[0][29:0]} : 32'd0;
            2'd2: nrd = (q.size() > 0) ? {28'd0, q[0][33:30]} : 32'd0;
            default: nrd = 32'd0;
         endcase
      end
      pushreq = dct_valid && m_en && !test_ending && (dct_count != 0);
      pop     = read && (address == 2'd2);
      flush   = write && (address == 2'd3) && writedata[2];
      clr     = write && (address == 2'd3) && writedata[1];
      dropped = 0;
      if (flush) q.delete();
      else begin
         if (pop && q.size() > 0) void'(q.pop_front());
         if (pushreq) begin
            if (q.size() < DEPTH) q.push_back({dct_count, dct_buffer});
            else dropped = 1;
         end
      end
      if (clr) begin m_ovf = 0; m_drop = 0; end
      else if (dropped) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
      if (write && address == 2'd3) m_en = writedata[0];
      if (test_has_ended) m_ended = 1;
      exp_rd = nrd;
      @(posedge clk); #1;
      check("readdata", readdata, exp_rd);
      dct_valid = 0; read = 0; write = 0; test_has_ended = 0;
   endtask

   task automatic push(input logic [29:0] b, input logic [3:0] c);
      dct_valid = 1; dct_buffer = b; dct_count = c;
      tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      address = a; read = 1;
      tick();
      v = readdata;
   endtask

   task automatic wr(input logic [31:0] d);
      address = 2'd3; write = 1; writedata = d;
      tick();
   endtask

   initial begin
      logic [31:0] v, r;
      reset_n = 0; dct_buffer = '0; dct_count = '0; dct_valid = 0;
      test_ending = 0; test_has_ended = 0; address = '0; read = 0; write = 0; writedata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_readdata", readdata, 32'd0);
      reset_n = 1;
      rd(2'd0, v); check("reset_status", v, 32'h0000_0009);

      // Three frames in, read back in order
      push(30'h1234567, 4'd5);
      push(30'h3FFFFFFF, 4'd10);
      push(30'h1, 4'd1);
      rd(2'd0, v); check("t1_status", v, 32'h0000_0308);
      rd(2'd1, v); check("t1_lo0", v, 32'h0123_4567);
      rd(2'd2, v); check("t1_hi0", v, 32'd5);
      rd(2'd1, v); check("t1_lo1", v, 32'h3FFF_FFFF);
      rd(2'd2, v); check("t1_hi1", v, 32'd10);
      rd(2'd1, v); check("t1_lo2", v, 32'd1);
      rd(2'd2, v); check("t1_hi2", v, 32'd1);
      rd(2'd0, v); check("t1_empty", v, 32'h0000_0009);
      rd(2'd2, v); check("t1_hi_empty", v, 32'd0);

      // Overfill, then push+pop while full
      for (int i = 0; i < 18; i++) push(30'(i * 32'h111 + 7), 4'(i % 12 + 1));
      rd(2'd0, v); check("t2_full", v, 32'h0002_100E);
      dct_valid = 1; dct_buffer = 30'h2ABCDEF; dct_count = 4'd15;
      address = 2'd2; read = 1;
      tick();
      check("t3_hi_first", readdata, 32'd1);
      rd(2'd0, v); check("t3_status", v, 32'h0002_100E);
      for (int i = 0; i < 15; i++) begin rd(2'd1, v); rd(2'd2, v); end
      rd(2'd1, v); check("t3_last_lo", v, 32'h02AB_CDEF);
      rd(2'd2, v); check("t3_last_hi", v, 32'd15);

      // Frames that must not be queued
      wr(32'h3);
      push(30'h55, 4'd0);
      test_ending = 1; push(30'h66, 4'd3); test_ending = 0;
      wr(32'h0);
      push(30'h77, 4'd4);
      rd(2'd0, v); check("t4_status", v, 32'h0000_0001);

      // Clear and flush together
      wr(32'h1);
      for (int i = 0; i < 17; i++) push(30'(i + 100), 4'd2);
      for (int i = 0; i < 11; i++) rd(2'd2, v);
      rd(2'd0, v); check("t5_before", v, 32'h0001_050C);
      wr(32'h7);
      rd(2'd0, v); check("t5_after", v, 32'h0000_0009);

      // Sticky ended, then reset mid-burst
      test_has_ended = 1; tick();
      push(30'h9, 4'd3);
      rd(2'd0, v); check("t6_ended", v, 32'h0000_0118);
      tick();
      rd(2'd0, v); check("t6_ended_hold", v, 32'h0000_0118);
      push(30'hA, 4'd3);
      dct_valid = 1; address = 2'd0; read = 1;
      #3 reset_n = 0;
      #1 check("t6_reset_async", readdata, 32'd0);
      @(posedge clk); #1;
      check("t6_reset_hold", readdata, 32'd0);
      dct_valid = 0; read = 0;
      reset_n = 1;
      model_reset();
      rd(2'd0, v); check("t6_after_reset", v, 32'h0000_0009);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         r = $urandom; dct_buffer = r[29:0];
         dct_count = 4'($urandom_range(0, 12));
         dct_valid = ($urandom_range(0, 1) == 1);
         test_ending = ($urandom_range(0, 9) == 0);
         test_has_ended = ($urandom_range(0, 299) == 0);
         r = $urandom; address = r[1:0];
         read = ($urandom_range(0, 2) != 0);
         write = ($urandom_range(0, 39) == 0);
         writedata = $urandom;
         if ($urandom_range(0, 3) != 0) writedata[0] = 1'b1;
         tick();
      end
      test_ending = 0;
      rd(2'd0, v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
